reset_release_sequencer: RTL
============================

Name: reset_release_sequencer

Overview:
- Sits downstream of the chip-level reset synchroniser and owns the per-subsystem reset lines (UART TX, UART RX, baud generator, register file, and so on).
- After global reset, or on a software-requested soft reset, it asserts all domain resets together, then releases them one at a time in index order.
- Before releasing the next domain it waits for the current domain's ready acknowledge, then a fixed stagger gap.
- A domain that never acknowledges causes a timeout. The block then re-asserts every domain reset and flags a sticky fault.

Parameters:
- NUM_DOMAINS, 4, number of reset domains; valid range 1..8.
- MIN_ASSERT, 2, cycles all resets stay asserted in ASSERT; must be ≥1.
- STAGGER_CYCLES, 3, gap cycles between one domain's ready and the next domain's release; must be ≥1.
- TIMEOUT_CYCLES, 16, edges waited for a ready before faulting; must be ≥1.
- CNT_W, 5, shared counter width; must hold max(MIN_ASSERT, STAGGER_CYCLES, TIMEOUT_CYCLES)-1.

Ports:
- clk  input  1  system clock; all flops on its posedge.
- rst_n  input  1  asynchronous active-low reset.
- soft_reset_req  input  1  synchronous level request; restart the sequence.
- domain_ready  input  NUM_DOMAINS  per-domain ready acknowledge; already synchronous to clk.
- reset_out  output  NUM_DOMAINS  per-domain reset, active-high, registered.
- busy  output  1  high in ASSERT, WAIT_RDY and GAP.
- all_released  output  1  high only in RUN.
- fault  output  1  sticky timeout flag.
- fault_domain  output  3  index of the domain that timed out; valid while fault=1.
- cur_domain  output  3  index the sequencer is currently working on.

Behaviour:
- rst_n=0 (async) sets the following; all outputs are registered and there are no combinational paths from inputs to outputs:
  - state=ASSERT, cnt=0, idx=0;
  - reset_out=all ones, fault=0, fault_domain=0;
  - busy=1, all_released=0, cur_domain=0.
- soft_reset_req=1 sampled at an edge has highest priority in every state. It produces:
  - state=ASSERT, cnt=0, idx=0;
  - reset_out=all ones, fault=0.
  - While the request is held high, the block stays in ASSERT with cnt held at 0.
- ASSERT:
  - If cnt==MIN_ASSERT-1: go to WAIT_RDY, cnt=0, idx=0, and clear reset_out[0] on that same edge.
  - Otherwise cnt++.
- WAIT_RDY(idx):
  - If domain_ready[idx]=1:
    - if idx==NUM_DOMAINS-1, go to RUN;
    - otherwise go to GAP with cnt=0.
  - Else if cnt==TIMEOUT_CYCLES-1: go to FAULT; reset_out=all ones; fault=1; fault_domain=idx.
  - Else cnt++.
  - If ready and timeout coincide on the same edge, ready wins.
- GAP:
  - If cnt==STAGGER_CYCLES-1: idx++, cnt=0, go to WAIT_RDY, and clear reset_out[idx+1] on that edge.
  - Otherwise cnt++.
- RUN:
  - reset_out=0, all_released=1.
  - Stays in RUN until soft_reset_req.
  - Changes on domain_ready are ignored.
- FAULT:
  - reset_out=all ones; fault, fault_domain and cur_domain are held.
  - Exit only via soft_reset_req or rst_n.
- Release order:
  - A released domain stays released until ASSERT or FAULT.
  - At every point, reset_out is a contiguous run of zeros from bit 0 up to idx.
- cur_domain = idx, zero-extended to 3 bits.
- NUM_DOMAINS=1: WAIT_RDY goes directly to RUN; GAP is never entered.
- Unused fault_domain and cur_domain bits are driven 0.

Test Plan:
- Nominal release:
  - Stimulus: defaults; rst_n released before edge 1; domain_ready=4'b1111.
  - Required: reset_out=1111 through edge 1, then 1110 after edge 2, 1100 after edge 6, 1000 after edge 10, 0000 after edge 14.
  - Required: all_released=1 and busy=0 after edge 15.
- Timeout:
  - Stimulus: domain_ready=4'b1101, so domain 1 never acknowledges.
  - Required: reset_out=1100 after edge 6.
  - Required: after edge 22, fault=1, fault_domain=1, reset_out=1111 and busy=0; state stays there for 20 more cycles.
- Ready on the final timeout edge:
  - Stimulus: domain_ready[0] rises only for the sample at edge 18, the edge where cnt==15.
  - Required: no fault; GAP is entered; reset_out[1] clears after edge 21.
- Soft reset mid-sequence:
  - Stimulus: assert soft_reset_req for the edge-8 sample, while in GAP after domain 1.
  - Required: reset_out=1111 after edge 8.
  - Required: the sequence restarts, with reset_out[0] clearing after edge 10.
- Soft reset clears FAULT and from RUN:
  - Stimulus: from FAULT, pulse soft_reset_req, then hold domain_ready high.
  - Required: fault=0 after the pulse edge; the full release sequence repeats and RUN is reached.
  - Stimulus: a second pulse while in RUN.
  - Required: all_released=0 and reset_out=1111 on the next edge.
- Async reset mid-operation:
  - Stimulus: drive rst_n low between edges while in WAIT_RDY for idx 2.
  - Required: reset_out=1111, cur_domain=0 and fault=0 immediately, without a clock edge.
  - Required: the nominal timing repeats once rst_n is high.

Source files
------------

// File: rtl/reset_release_sequencer_if.sv
// Control/status bundle between the reset sequencer and its surroundings.
// The sequencer takes the slave view; the controller or bench takes the master view.
interface reset_release_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   soft_reset_req;
  logic [NUM_DOMAINS-1:0] domain_ready;
  logic [NUM_DOMAINS-1:0] reset_out;
  logic                   busy;
  logic                   all_released;
  logic                   fault;
  logic [2:0]             fault_domain;
  logic [2:0]             cur_domain;

  modport slave (
    input  soft_reset_req, domain_ready,
    output reset_out, busy, all_released, fault, fault_domain, cur_domain
  );

  modport master (
    output soft_reset_req, domain_ready,
    input  reset_out, busy, all_released, fault, fault_domain, cur_domain
  );
endinterface

// File: rtl/reset_release_sequencer.sv
// Asserts all domain resets, then releases them one by one in index order, waiting for each
// domain's ready plus a stagger gap; a missing ready re-asserts everything and latches a fault.
module reset_release_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int MIN_ASSERT     = 2,
  parameter int STAGGER_CYCLES = 3,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  reset_release_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_ASSERT   = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_GAP      = 3'd2,
    S_RUN      = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX     = 3'(NUM_DOMAINS - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] reset_out_q, reset_out_d;
  logic                   fault_q, fault_d;
  logic [2:0]             fault_domain_q, fault_domain_d;
  logic                   busy_q, busy_d;
  logic                   all_released_q, all_released_d;
  logic [7:0]             rdy_ext;

  // Widened so a 3-bit index always selects in range regardless of NUM_DOMAINS.
  assign rdy_ext = 8'(bus.domain_ready);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    fault_d        = fault_q;
    fault_domain_d = fault_domain_q;

    if (bus.soft_reset_req) begin
      state_d = S_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        S_ASSERT: begin
          if (cnt_q == ASSERT_LAST) begin
            state_d = S_WAIT_RDY;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_RDY: begin
          // Ready is checked first so it wins over a coincident timeout.
          if (rdy_ext[idx_q]) begin
            cnt_d   = '0;
            state_d = (idx_q == LAST_IDX) ? S_RUN : S_GAP;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d        = S_FAULT;
            fault_d        = 1'b1;
            fault_domain_d = idx_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == STAGGER_LAST) begin
            state_d = S_WAIT_RDY;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN, S_FAULT: ;
        default: begin
          state_d = S_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    // Released domains are always the contiguous run 0..idx.
    reset_out_d = '1;
    case (state_d)
      S_RUN: reset_out_d = '0;
      S_WAIT_RDY, S_GAP: begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          reset_out_d[i] = (3'(i) > idx_d);
        end
      end
      default: reset_out_d = '1;
    endcase

    busy_d         = (state_d == S_ASSERT) || (state_d == S_WAIT_RDY) || (state_d == S_GAP);
    all_released_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_ASSERT;
      cnt_q          <= '0;
      idx_q          <= '0;
      reset_out_q    <= '1;
      fault_q        <= 1'b0;
      fault_domain_q <= '0;
      busy_q         <= 1'b1;
      all_released_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      reset_out_q    <= reset_out_d;
      fault_q        <= fault_d;
      fault_domain_q <= fault_domain_d;
      busy_q         <= busy_d;
      all_released_q <= all_released_d;
    end
  end

  assign bus.reset_out    = reset_out_q;
  assign bus.busy         = busy_q;
  assign bus.all_released = all_released_q;
  assign bus.fault        = fault_q;
  assign bus.fault_domain = fault_domain_q;
  assign bus.cur_domain   = idx_q;

endmodule
